// File: rtl/tx_flit_queue_if.sv
// rtl/tx_flit_queue_if.sv - router-side flit handshake for tx_flit_queue
// Flit layout macros are defined here unless the surrounding build supplies them.
`ifndef PKTW
`define PKTW 31
`endif
`ifndef FLOWBH
`define FLOWBH 31
`endif
`ifndef FLOWBL
`define FLOWBL 30
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

interface tx_flit_queue_if;
  logic [`PKTW:0] out_flit;
  logic           out_valid;
  logic           out_ready;

  modport master (output out_flit, output out_valid, input out_ready);
  modport slave  (input out_flit, input out_valid, output out_ready);
endinterface

// File: rtl/tx_flit_queue.sv
// rtl/tx_flit_queue.sv - packet-admission flit queue between PU transmit port and router
// Optional TXQ_STORE_FWD_EN: hold out_valid until a complete packet is queued.
`ifndef PKTW
`define PKTW 31
`endif
`ifndef FLOWBH
`define FLOWBH 31
`endif
`ifndef FLOWBL
`define FLOWBL 30
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tx_flit_queue #(
  parameter int DEPTH     = 64,
  parameter int MAX_FLITS = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [`PKTW:0]          in_flit,
  tx_flit_queue_if.master         tx,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              drop_cnt,
  output logic                    proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] MAX_L   = MAX_FLITS[AW:0];

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;

  logic [`PKTW:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  state_t         state;
  state_t         state_nxt;

  logic [`FLOWBH-`FLOWBL:0] ftype;
  logic is_head, is_body, is_tail;
  logic full, push, pop, perr_set, drop_inc;

  assign ftype   = in_flit[`FLOWBH:`FLOWBL];
  assign is_head = (ftype == `HEAD);
  assign is_body = (ftype == `BODY);
  assign is_tail = (ftype == `TAIL);
  assign full    = (level == DEPTH_L);

  assign tx.out_flit = mem[rd_ptr];
  assign pop         = tx.out_valid && tx.out_ready;

  // Admission reserves room for a worst-case packet, so an accepted packet never overflows.
  always_comb begin
    push      = 1'b0;
    perr_set  = 1'b0;
    drop_inc  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (is_head) begin
          if ((DEPTH_L - level) >= MAX_L) begin
            push      = 1'b1;
            state_nxt = ACCEPT;
          end else begin
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end
        end else if (is_body || is_tail) begin
          perr_set = 1'b1;
        end
      end
      ACCEPT: begin
        if (is_head) begin
          perr_set = 1'b1;
        end else if (is_body || is_tail) begin
          if (full) perr_set = 1'b1;
          else      push     = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (is_tail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TXQ_STORE_FWD_EN
  logic [AW:0] pkt_cnt;
  logic        push_tail, pop_tail;
  assign push_tail    = push && is_tail;
  assign pop_tail     = pop && (tx.out_flit[`FLOWBH:`FLOWBL] == `TAIL);
  assign tx.out_valid = (pkt_cnt != '0);
`else
  assign tx.out_valid = (level != '0);
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
`ifdef TXQ_STORE_FWD_EN
      pkt_cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
      if (perr_set) proto_err <= 1'b1;
`ifdef TXQ_STORE_FWD_EN
      if (push_tail && !pop_tail)      pkt_cnt <= pkt_cnt + 1'b1;
      else if (pop_tail && !push_tail) pkt_cnt <= pkt_cnt - 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_tx_flit_queue.sv
// tb/tb_tx_flit_queue.sv - randomized self-checking bench for tx_flit_queue against a queue model
`ifndef PKTW
`define PKTW 31
`endif
`ifndef FLOWBH
`define FLOWBH 31
`endif
`ifndef FLOWBL
`define FLOWBL 30
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tb_tx_flit_queue;
  localparam int DEPTH     = 64;
  localparam int MAX_FLITS = 34;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [`PKTW:0]         in_flit = '0;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             drop_cnt;
  logic                   proto_err;

  tx_flit_queue_if txq ();

  tx_flit_queue #(.DEPTH(DEPTH), .MAX_FLITS(MAX_FLITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .tx        (txq),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: stored flits, packet mode (0 waiting for head, 1 inside accepted packet, 2 discarding).
  logic [`PKTW:0] q[$];
  int             mode = 0;
  int             m_drop = 0;
  bit             m_perr = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [`PKTW:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  function automatic bit m_valid();
`ifdef TXQ_STORE_FWD_EN
    foreach (q[i]) if (q[i][`FLOWBH:`FLOWBL] == `TAIL) return 1'b1;
    return 1'b0;
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic model_step(input logic [`PKTW:0] f, input bit ready);
    logic [1:0] t;
    bit pop, push;
    int free;
    t    = f[`FLOWBH:`FLOWBL];
    pop  = m_valid() && ready && (q.size() != 0);
    push = 1'b0;
    free = DEPTH - q.size();
    if (t != 2'b00) begin
      case (mode)
        0: begin
          if (t == `HEAD) begin
            if (free >= MAX_FLITS) begin push = 1'b1; mode = 1; end
            else begin if (m_drop < 255) m_drop++; mode = 2; end
          end else m_perr = 1'b1;
        end
        1: begin
          if (t == `HEAD) m_perr = 1'b1;
          else begin
            if (q.size() == DEPTH) m_perr = 1'b1;
            else push = 1'b1;
            if (t == `TAIL) mode = 0;
          end
        end
        default: if (t == `TAIL) mode = 0;
      endcase
    end
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(f);
  endtask

  task automatic check_outputs();
    check_val("level", level, q.size());
    check_val("drop_cnt", drop_cnt, m_drop);
    check_val("proto_err", proto_err, m_perr);
    check_val("out_valid", txq.out_valid, m_valid());
    if (m_valid()) check_val("out_flit", txq.out_flit, q[0]);
  endtask

  // Called at a negedge: check state after the last edge, drive new inputs, step the model.
  task automatic cycle(input logic [`PKTW:0] f, input bit ready);
    check_outputs();
    in_flit       = f;
    txq.out_ready = ready;
    model_step(f, ready);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_flit = '0;
    rst_n   = 1'b0;
    #1;
    check_val("rst_out_valid", txq.out_valid, 0);
    check_val("rst_level", level, 0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    check_val("rst_proto_err", proto_err, 0);
    q.delete();
    mode   = 0;
    m_drop = 0;
    m_perr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_pkt(input int len, input bit ready);
    cycle(mk(`HEAD, 30'($urandom)), ready);
    for (int i = 0; i < len - 2; i++) cycle(mk(`BODY, 30'($urandom)), ready);
    cycle(mk(`TAIL, 30'($urandom)), ready);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) cycle(mk(2'b00, 30'($urandom)), ready);
  endtask

  initial begin
    logic [`PKTW:0] pend[$];
    txq.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Short packet, router always ready.
    cycle(mk(`HEAD, 30'h3), 1'b1);
    for (int i = 0; i < 4; i++) cycle(mk(`BODY, 30'h100 + 30'(i)), 1'b1);
    cycle(mk(`TAIL, 30'h3FF), 1'b1);
    idle(8, 1'b1);
    check_val("short_pkt_drained", level, 0);

    // Stray BODY while idle.
    do_reset();
    cycle(mk(`BODY, 30'h5A), 1'b1);
    idle(2, 1'b1);
    check_val("stray_body_perr", proto_err, 1);
    check_val("stray_body_level", level, 0);

    // Full-size packet blocks, next packet lacks room.
    do_reset();
    send_pkt(MAX_FLITS, 1'b0);
    send_pkt(5, 1'b0);
    idle(2, 1'b0);
    check_val("blocked_level", level, MAX_FLITS);
    check_val("blocked_drop", drop_cnt, 1);
    idle(MAX_FLITS + 4, 1'b1);
    check_val("blocked_drained", level, 0);

    // Store-forward style gap before TAIL.
    send_pkt(2, 1'b1);
    cycle(mk(`HEAD, 30'h11), 1'b1);
    for (int i = 0; i < 3; i++) cycle(mk(`BODY, 30'h20 + 30'(i)), 1'b1);
    idle(3, 1'b1);
    cycle(mk(`TAIL, 30'h2F), 1'b1);
    idle(8, 1'b1);

    // Reset mid-packet, remainder is a protocol error.
    cycle(mk(`HEAD, 30'h7), 1'b0);
    cycle(mk(`BODY, 30'h8), 1'b0);
    cycle(mk(`BODY, 30'h9), 1'b0);
    do_reset();
    cycle(mk(`BODY, 30'hA), 1'b1);
    cycle(mk(`TAIL, 30'hB), 1'b1);
    check_val("post_reset_perr", proto_err, 1);
    check_val("post_reset_level", level, 0);

    // Randomized traffic with gaps, backpressure and stray flits.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit rdy;
      if (pend.size() == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          pend.push_back(mk(2'($urandom_range(1, 3)), 30'($urandom)));
        end else begin
          int len = $urandom_range(2, MAX_FLITS);
          pend.push_back(mk(`HEAD, 30'($urandom)));
          for (int i = 0; i < len - 2; i++) pend.push_back(mk(`BODY, 30'($urandom)));
          pend.push_back(mk(`TAIL, 30'($urandom)));
        end
      end
      rdy = ((c / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) cycle(mk(2'b00, 30'($urandom)), rdy);
      else cycle(pend.pop_front(), rdy);
    end
    while (pend.size() != 0) cycle(pend.pop_front(), 1'b1);
    idle(DEPTH + 8, 1'b1);
    check_val("random_drained", level, 0);

    // Drop counter saturation.
    do_reset();
    send_pkt(MAX_FLITS, 1'b0);
    for (int p = 0; p < 300; p++) send_pkt(2, 1'b0);
    idle(1, 1'b0);
    check_val("drop_saturate", drop_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_flit_queue.md
TX_FLIT_QUEUE -- requirements
Module: tx_flit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 64, flit storage entries (power of two, at least 4).
REQ-002 SHALL have parameter MAX_FLITS, default 34, largest legal packet length in flits including HEAD and TAIL (at most DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_flit  input  `PKTW+1  flit from the PU data-memory transmit output; type field [`FLOWBH:`FLOWBL] is `HEAD/`BODY/`TAIL, all-zero type means idle; no backpressure.
REQ-006 SHALL have port out_flit  output  `PKTW+1  flit at queue head, toward router input port.
REQ-007 SHALL have port out_valid  output  1  out_flit is valid.
REQ-008 SHALL have port out_ready  input  1  router accepts out_flit.
REQ-009 SHALL have port level  output  $clog2(DEPTH)+1  flits currently stored.
REQ-010 SHALL have port drop_cnt  output  8  packets dropped at admission, saturating.
REQ-011 SHALL have port proto_err  output  1  sticky flit-sequence error flag.

Function
REQ-012 SHALL run an input FSM with states IDLE, ACCEPT, DROP; idle flits SHALL be ignored in every state.
REQ-013 IDLE + HEAD: if DEPTH-level (level before this cycle's pop) >= MAX_FLITS, SHALL write HEAD and go to ACCEPT; otherwise SHALL discard it, increment drop_cnt (saturate at 255), go to DROP.
REQ-014 IDLE + BODY or TAIL: SHALL discard the flit, set proto_err, stay IDLE.
REQ-015 ACCEPT + BODY: SHALL write the flit; ACCEPT + TAIL: SHALL write the flit and go to IDLE.
REQ-016 ACCEPT + HEAD: SHALL discard the flit, set proto_err, stay ACCEPT.
REQ-017 ACCEPT with queue full: SHALL discard the incoming flit and set proto_err; a TAIL discarded this way SHALL still return the FSM to IDLE.
REQ-018 DROP: SHALL discard all flits; TAIL SHALL return the FSM to IDLE.
REQ-019 Storage SHALL be a circular buffer; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 out_flit SHALL be the entry at the read pointer; a pop SHALL occur when out_valid and out_ready are both high in the same cycle.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; push alone increments it, pop alone decrements it.
REQ-022 A written flit SHALL be visible on out_flit with out_valid high no earlier than the cycle after the write edge; the queue SHALL NOT bypass input to output.
REQ-023 Flit order SHALL be preserved, and flits of different packets SHALL never interleave.

Reset
REQ-024 rst_n low SHALL immediately force: pointers 0, level 0, out_valid 0, drop_cnt 0, proto_err 0, FSM IDLE, packet count 0.
REQ-025 Reset mid-packet SHALL discard all stored flits; the remainder of the interrupted packet SHALL be handled per REQ-014.

Configuration
REQ-026 Macro TXQ_STORE_FWD_EN defined: SHALL keep a count of complete packets (TAIL written) in the queue, incremented on TAIL write and decremented on TAIL pop (simultaneous: unchanged); out_valid = count != 0.
REQ-027 Macro TXQ_STORE_FWD_EN undefined: SHALL operate cut-through with out_valid = (level != 0) and SHALL NOT implement the packet count.

Verification
REQ-028 Cut-through, out_ready=1: HEAD(port 3), 4 BODY, TAIL on consecutive cycles -> same 6 flits out in order; out_valid first high the cycle after HEAD is written; level returns to 0.
REQ-029 out_ready=0: 34-flit packet, then HEAD -> second packet dropped (free 30 < 34); drop_cnt=1; level=34; releasing out_ready yields the first packet intact.
REQ-030 BODY 0x5A arriving in IDLE -> proto_err=1, level stays 0, out_valid stays 0.
REQ-031 TXQ_STORE_FWD_EN, out_ready=1: HEAD, 3 BODY, gap, TAIL -> out_valid 0 until the cycle after TAIL is written, then 5 contiguous flits.
REQ-032 rst_n low after HEAD + 2 BODY -> out_valid 0 and level 0 that cycle; the following BODY sets proto_err and is not stored.
REQ-033 300 packets offered with out_ready=0 and queue full -> drop_cnt saturates at 255.
